// File: rtl/seven_segment_scan_decoder.sv
// Recovers digit values from a multiplexed seven-segment bus: waits for a settled one-hot
// selection, inverse-decodes the segment pattern and stores it as {enable, dp, hex[3:0]}.
module seven_segment_scan_decoder #(
    parameter int NUMBER_OF_DIGITS = 4,
    parameter bit CATHODE_COMMON   = 1'b1,
    parameter int SETTLE_CYCLES    = 4,
    localparam int INDEX_WIDTH     = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [7:0]                  segment_in,
    input  logic [NUMBER_OF_DIGITS-1:0] digit_selector_in,
    output logic [5:0]                  digits [0:NUMBER_OF_DIGITS-1],
    output logic                        digit_update,
    output logic [INDEX_WIDTH-1:0]      digit_index,
    output logic                        decode_error,
    output logic                        frame_done
);

    localparam int N       = NUMBER_OF_DIGITS;
    localparam int COUNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    logic [N-1:0]       sel_meta_reg, sel_sync_reg;
    logic [7:0]         seg_meta_reg, seg_sync_reg;
    logic [N-1:0]       sel;
    logic [7:0]         seg;
    logic               sel_one_hot;
    logic [INDEX_WIDTH-1:0] sel_index;
    logic [N+7:0]       prev_reg;
    logic               stable;
    state_t             state_reg, state_next;
    logic [COUNT_W-1:0] count_reg, count_next;
    logic               capture;
    logic               hex_valid;
    logic [3:0]         hex_value;
    logic               blank, digit_ok;
    logic [5:0]         new_digit;
    logic [N-1:0]       seen_reg, seen_next;
    logic               frame_complete;

    // Synchroniser flops reset to the raw level that normalises to "nothing selected, all dark".
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_meta_reg <= {N{CATHODE_COMMON}};
            sel_sync_reg <= {N{CATHODE_COMMON}};
            seg_meta_reg <= {8{~CATHODE_COMMON}};
            seg_sync_reg <= {8{~CATHODE_COMMON}};
        end else begin
            sel_meta_reg <= digit_selector_in;
            sel_sync_reg <= sel_meta_reg;
            seg_meta_reg <= segment_in;
            seg_sync_reg <= seg_meta_reg;
        end
    end

    assign sel         = CATHODE_COMMON ? ~sel_sync_reg : sel_sync_reg;
    assign seg         = CATHODE_COMMON ? seg_sync_reg : ~seg_sync_reg;
    assign sel_one_hot = $onehot(sel);
    assign stable      = ({sel, seg} == prev_reg);

    always_comb begin
        sel_index = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) sel_index = INDEX_WIDTH'(i);
        end
    end

    always_comb begin
        hex_valid = 1'b1;
        hex_value = 4'h0;
        case (seg[6:0])
            7'h3F: hex_value = 4'h0;
            7'h06: hex_value = 4'h1;
            7'h5B: hex_value = 4'h2;
            7'h4F: hex_value = 4'h3;
            7'h66: hex_value = 4'h4;
            7'h6D: hex_value = 4'h5;
            7'h7D: hex_value = 4'h6;
            7'h07: hex_value = 4'h7;
            7'h7F: hex_value = 4'h8;
            7'h6F: hex_value = 4'h9;
            7'h77: hex_value = 4'hA;
            7'h7C: hex_value = 4'hB;
            7'h39: hex_value = 4'hC;
            7'h5E: hex_value = 4'hD;
            7'h79: hex_value = 4'hE;
            7'h71: hex_value = 4'hF;
            default: hex_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            prev_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            prev_reg  <= {sel, seg};
        end
    end

    // The counter holds the number of consecutive samples seen with the current {sel, seg}.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (sel_one_hot) begin
                    state_next = SETTLE;
                    count_next = COUNT_W'(1);
                end
            end
            SETTLE: begin
                if (!sel_one_hot) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (!stable) begin
                    count_next = COUNT_W'(1);
                end else if (count_reg == COUNT_W'(SETTLE_CYCLES)) begin
                    capture    = 1'b1;
                    state_next = CAPTURED;
                    count_next = '0;
                end else begin
                    count_next = count_reg + COUNT_W'(1);
                end
            end
            CAPTURED: begin
                if (sel != prev_reg[N+7:8]) begin
                    state_next = sel_one_hot ? SETTLE : IDLE;
                    count_next = sel_one_hot ? COUNT_W'(1) : '0;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign blank          = (seg == 8'h00);
    assign digit_ok       = blank || hex_valid;
    assign new_digit      = blank ? 6'h00 : {1'b1, seg[7], hex_value};
    assign seen_next      = seen_reg | (capture ? sel : '0);
    assign frame_complete = capture && (&seen_next);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) digits[i] <= 6'h00;
            digit_update <= 1'b0;
            decode_error <= 1'b0;
            frame_done   <= 1'b0;
            digit_index  <= '0;
            seen_reg     <= '0;
        end else begin
            digit_update <= capture && digit_ok;
            decode_error <= capture && !digit_ok;
            frame_done   <= frame_complete;
            seen_reg     <= frame_complete ? '0 : seen_next;
            if (capture) digit_index <= sel_index;
            for (int i = 0; i < N; i++) begin
                if (capture && digit_ok && sel[i]) digits[i] <= new_digit;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: decode vector table, multi-cycle corner sequences
// and a randomized scan checked against a run-length reference model.
module tb_seven_segment_scan_decoder;
    localparam int N = 4;
    localparam int S = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] seg_a, seg_b;
    logic [3:0] sel_a, sel_b;
    logic [5:0] digits_a [0:N-1];
    logic [5:0] digits_b [0:N-1];
    logic       upd_a, err_a, fd_a, upd_b, err_b, fd_b;
    logic [1:0] idx_a, idx_b;

    always #5 clock = ~clock;

    seven_segment_scan_decoder #(.NUMBER_OF_DIGITS(N), .CATHODE_COMMON(1'b1), .SETTLE_CYCLES(S)) dut_a (
        .clock(clock), .reset_n(reset_n), .segment_in(seg_a), .digit_selector_in(sel_a),
        .digits(digits_a), .digit_update(upd_a), .digit_index(idx_a),
        .decode_error(err_a), .frame_done(fd_a));

    seven_segment_scan_decoder #(.NUMBER_OF_DIGITS(N), .CATHODE_COMMON(1'b0), .SETTLE_CYCLES(S)) dut_b (
        .clock(clock), .reset_n(reset_n), .segment_in(seg_b), .digit_selector_in(sel_b),
        .digits(digits_b), .digit_update(upd_b), .digit_index(idx_b),
        .decode_error(err_b), .frame_done(fd_b));

    typedef struct packed {
        logic [1:0] idx;
        logic       err;
        logic [5:0] val;
        logic       fd;
    } event_t;

    typedef struct packed {
        logic [1:0] d;
        logic [7:0] seg;
        logic       err;
        logic [5:0] val;
        logic       fd;
    } vec_t;

    event_t     ev_q[$];
    event_t     exp_q[$];
    event_t     mon_e;
    int         stray = 0;
    int         upd_b_count = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    vec_t       vecs [18];
    logic [6:0] pat [16];

    // Every pulse of dut_a is logged with the digit value visible right after it.
    always @(negedge clock) begin
        if (upd_a || err_a) begin
            mon_e.idx = idx_a;
            mon_e.err = err_a;
            mon_e.val = digits_a[idx_a];
            mon_e.fd  = fd_a;
            ev_q.push_back(mon_e);
        end
        if ((fd_a && !(upd_a || err_a)) || (upd_a && err_a)) stray++;
        if (upd_b) upd_b_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pick(input int d);
        logic [3:0] one;
        one = 4'b0001 << d;
        return ~one;
    endfunction

    task automatic set_a(input logic [3:0] raw_sel, input logic [7:0] seg);
        sel_a = raw_sel;
        seg_a = seg;
    endtask

    // Drive a digit just after a rising edge and hold it for n further edges.
    task automatic show(input int d, input logic [7:0] seg, input int n);
        @(posedge clock);
        #1;
        set_a(pick(d), seg);
        repeat (n) @(posedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_a(4'hF, 8'h00);
        sel_b = 4'h0;
        seg_b = 8'hFF;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic expect_one(input string name, input event_t exp);
        @(negedge clock);
        check({name, "_count"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            check(name, ev_q[0], exp);
            $display("%s: idx=%0d err=%0b val=%02h fd=%0b", name, ev_q[0].idx, ev_q[0].err,
                     ev_q[0].val, ev_q[0].fd);
        end
        ev_q.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        event_t e;
        logic [3:0] psel, rsel, sel_n;
        logic [7:0] pseg, rseg;
        logic [5:0] mdig [0:N-1];
        logic [3:0] mmask;
        int cap, len, d, found;

        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0]  = {2'd0, 8'h3F, 1'b0, 6'h20, 1'b0};
        vecs[1]  = {2'd1, 8'h06, 1'b0, 6'h21, 1'b0};
        vecs[2]  = {2'd2, 8'h5B, 1'b0, 6'h22, 1'b0};
        vecs[3]  = {2'd3, 8'hCF, 1'b0, 6'h33, 1'b1};
        vecs[4]  = {2'd2, 8'h49, 1'b1, 6'h22, 1'b0};
        vecs[5]  = {2'd0, 8'h77, 1'b0, 6'h2A, 1'b0};
        vecs[6]  = {2'd1, 8'hFC, 1'b0, 6'h3B, 1'b0};
        vecs[7]  = {2'd3, 8'h00, 1'b0, 6'h00, 1'b1};
        vecs[8]  = {2'd0, 8'h80, 1'b1, 6'h2A, 1'b0};
        vecs[9]  = {2'd1, 8'h39, 1'b0, 6'h2C, 1'b0};
        vecs[10] = {2'd2, 8'h5E, 1'b0, 6'h2D, 1'b0};
        vecs[11] = {2'd3, 8'h79, 1'b0, 6'h2E, 1'b1};
        vecs[12] = {2'd0, 8'h71, 1'b0, 6'h2F, 1'b0};
        vecs[13] = {2'd1, 8'h66, 1'b0, 6'h24, 1'b0};
        vecs[14] = {2'd2, 8'h7D, 1'b0, 6'h26, 1'b0};
        vecs[15] = {2'd3, 8'hEF, 1'b0, 6'h39, 1'b1};
        vecs[16] = {2'd0, 8'h6D, 1'b0, 6'h25, 1'b0};
        vecs[17] = {2'd2, 8'h4F, 1'b0, 6'h23, 1'b0};

        // Reset state, sampled while reset is held.
        reset_n = 1'b0;
        set_a(4'hF, 8'h00);
        sel_b = 4'h0;
        seg_b = 8'hFF;
        @(negedge clock);
        for (int i = 0; i < N; i++) check("reset_digit", digits_a[i], 6'h00);
        check("reset_pulses", {upd_a, err_a, fd_a}, 3'b000);
        check("reset_index", idx_a, 2'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Inverted-polarity instance: selector active-high, segments active-low.
        sel_b = 4'b0001;
        seg_b = ~8'h6D;
        repeat (12) @(posedge clock);
        @(negedge clock);
        check("cc0_digit0", digits_b[0], 6'h25);
        check("cc0_updates", upd_b_count, 1);
        $display("cc0: digits_b[0]=%02h updates=%0d", digits_b[0], upd_b_count);
        sel_b = 4'h0;
        seg_b = 8'hFF;

        ev_q.delete();
        for (int i = 0; i < 18; i++) begin
            show(int'(vecs[i].d), vecs[i].seg, 10);
            expect_one($sformatf("vec%0d", i), {vecs[i].d, vecs[i].err, vecs[i].val, vecs[i].fd});
        end

        // Pattern held for only three edges before changing restarts the settle window.
        show(1, 8'h07, 2);
        show(1, 8'h7F, 10);
        expect_one("short_hold", {2'd1, 1'b0, 6'h28, 1'b0});

        // Two selected, then none selected: no activity at all.
        @(posedge clock);
        #1;
        set_a(4'b1001, 8'h3F);
        repeat (20) @(posedge clock);
        #1;
        set_a(4'b1111, 8'h3F);
        repeat (20) @(posedge clock);
        @(negedge clock);
        check("not_one_hot_events", ev_q.size(), 0);
        $display("not_one_hot: events=%0d", ev_q.size());

        // Latency: pulse appears after the seventh rising edge following the pin change.
        @(posedge clock);
        #1;
        set_a(pick(3), 8'h06);
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("latency_early", upd_a, 1'b0);
        @(negedge clock);
        check("latency_on_time", upd_a, 1'b1);
        $display("latency: update seen on edge 7");
        repeat (3) @(posedge clock);
        expect_one("latency_event", {2'd3, 1'b0, 6'h21, 1'b1});

        // Reset mid-frame and mid-settle clears everything without a pulse.
        do_reset();
        show(0, 8'h3F, 10);
        show(1, 8'h06, 10);
        show(2, 8'h5B, 10);
        show(3, 8'h4F, 3);
        ev_q.delete();
        #1;
        reset_n = 1'b0;
        set_a(4'hF, 8'h00);
        @(negedge clock);
        for (int i = 0; i < N; i++) check("midreset_digit", digits_a[i], 6'h00);
        check("midreset_index", idx_a, 2'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("midreset_no_pulse", ev_q.size(), 0);
        show(3, 8'h66, 10);
        expect_one("post_reset_d3", {2'd3, 1'b0, 6'h24, 1'b0});
        show(0, 8'h06, 10);
        expect_one("post_reset_d0", {2'd0, 1'b0, 6'h21, 1'b0});
        show(1, 8'h5B, 10);
        expect_one("post_reset_d1", {2'd1, 1'b0, 6'h22, 1'b0});
        show(2, 8'h4F, 10);
        expect_one("post_reset_d2", {2'd2, 1'b0, 6'h23, 1'b1});

        // Randomized scan: runs of constant pins; model decides per run whether it captures.
        do_reset();
        ev_q.delete();
        exp_q.delete();
        for (int i = 0; i < N; i++) mdig[i] = 6'h00;
        mmask = 4'h0;
        cap = -1;
        psel = 4'hF;
        pseg = 8'h00;
        for (int r = 0; r < 200; r++) begin
            do begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: rsel = pick(int'($urandom_range(0, 3)));
                    6, 7:             rsel = 4'($urandom_range(0, 15));
                    default:          rsel = psel;
                endcase
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: rseg = {1'($urandom_range(0, 1)), pat[$urandom_range(0, 15)]};
                    6:                rseg = 8'h00;
                    7:                rseg = 8'h80;
                    default:          rseg = 8'($urandom_range(0, 255));
                endcase
            end while ({rsel, rseg} == {psel, pseg});
            len = $urandom_range(1, 9);
            set_a(rsel, rseg);
            repeat (len) @(posedge clock);
            #1;

            sel_n = ~rsel;
            if ($countones(sel_n) != 1) begin
                cap = -1;
            end else begin
                d = 0;
                for (int k = 0; k < N; k++) if (sel_n[k]) d = k;
                if (d != cap) begin
                    if (len >= S + 1) begin
                        found = -1;
                        for (int k = 0; k < 16; k++) if (pat[k] == rseg[6:0]) found = k;
                        e.idx = 2'(d);
                        if (rseg == 8'h00) begin
                            e.err = 1'b0;
                            mdig[d] = 6'h00;
                        end else if (found >= 0) begin
                            e.err = 1'b0;
                            mdig[d] = {1'b1, rseg[7], 4'(found)};
                        end else begin
                            e.err = 1'b1;
                        end
                        e.val = mdig[d];
                        mmask[d] = 1'b1;
                        e.fd = &mmask;
                        if (e.fd) mmask = 4'h0;
                        exp_q.push_back(e);
                        cap = d;
                    end else begin
                        cap = -1;
                    end
                end
            end
            psel = rsel;
            pseg = rseg;
        end
        set_a(4'hF, 8'h00);
        repeat (12) @(posedge clock);
        @(negedge clock);
        check("rand_event_count", ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            check($sformatf("rand_event%0d", i), ev_q[i], exp_q[i]);
            $display("rand %0d: idx=%0d err=%0b val=%02h fd=%0b", i, ev_q[i].idx, ev_q[i].err,
                     ev_q[i].val, ev_q[i].fd);
        end
        for (int i = 0; i < N; i++) check("rand_final_digit", digits_a[i], mdig[i]);
        check("stray_pulses", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
